// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register file and its line filters.
package i2c_pkg;

  localparam int BYTE_W = 8;
  localparam int ADDR_W = 7;

  localparam logic ACK = 1'b0;
  localparam logic NAK = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    SUB,
    SUB_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_t;

  function automatic int ptr_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one I2C line,
// with one-clock rise/fall pulses aligned to the filtered value changing.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt,
  output logic rise,
  output logic fall
);

  logic       sync1;
  logic       sync2;
  logic [2:0] cnt;
  logic       update;

  // The counter tracks how long the synchronised sample has disagreed with the filtered value.
  assign update = (sync2 != filt) && (cnt == 3'(FILT_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      filt  <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= update && sync2;
      fall  <= update && !sync2;
      if ((sync2 == filt) || update) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 3'd1;
      end
      if (update) begin
        filt <= sync2;
      end
    end
  end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with an auto-incrementing register file: sub-address write,
// burst writes, and repeated-START burst reads.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR  = 7'h70,
  parameter int         NUM_REGS  = 16,
  parameter int         FILT_LEN  = 3,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [NUM_REGS*8-1:0] regs_q,
  output logic                  wr_stb,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [BYTE_W-1:0]     wr_data,
  output logic                  busy
);

  localparam int               PTR_W      = ptr_width(NUM_REGS);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(NUM_REGS - 1);
  localparam logic [BYTE_W:0]  NUM_REGS_W = 9'(NUM_REGS);

  logic scl, sda, scl_rise, scl_fall, sda_rise, sda_fall;

  state_t             state;
  logic [3:0]         bit_cnt;
  logic [BYTE_W-1:0]  shift;
  logic [BYTE_W-2:0]  tx;
  logic               rw;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_next;
  logic [BYTE_W-1:0]  regs [NUM_REGS];

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rst_n(rst_n), .raw(scl_in), .filt(scl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rst_n(rst_n), .raw(sda_in), .filt(sda), .rise(sda_rise), .fall(sda_fall)
  );

  assign ptr_next = (ptr == LAST_PTR) ? '0 : ptr + 1'b1;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_q
    assign regs_q[8*i +: 8] = regs[i];
  end

  // Bits are shifted in on every SCL rise; all decisions and SDA drive changes happen on SCL falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= '0;
      rw      <= 1'b0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      wr_stb <= 1'b0;
      if (scl_rise) begin
        shift   <= {shift[BYTE_W-2:0], sda};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (sda_fall && scl) begin
        state   <= ADDR;
        bit_cnt <= '0;
      end else if (sda_rise && scl) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (scl_fall) begin
        case (state)
          ADDR: if (bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            if (shift[7:1] == I2C_ADDR) begin
              sda_oe <= 1'b1;
              busy   <= 1'b1;
              rw     <= shift[0];
              state  <= ADDR_ACK;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          ADDR_ACK: begin
            bit_cnt <= '0;
            if (rw) begin
              tx     <= regs[ptr][6:0];
              sda_oe <= ~regs[ptr][7];
              state  <= RDATA;
            end else begin
              sda_oe <= 1'b0;
              state  <= SUB;
            end
          end
          SUB: if (bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            if ({1'b0, shift} < NUM_REGS_W) begin
              sda_oe <= 1'b1;
              ptr    <= shift[PTR_W-1:0];
              state  <= SUB_ACK;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          SUB_ACK, WDATA_ACK: begin
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
            state   <= WDATA;
          end
          WDATA: if (bit_cnt == 4'd8) begin
            bit_cnt   <= '0;
            sda_oe    <= 1'b1;
            regs[ptr] <= shift;
            wr_stb    <= 1'b1;
            wr_addr   <= 7'(ptr);
            wr_data   <= shift;
            ptr       <= ptr_next;
            state     <= WDATA_ACK;
          end
          RDATA: begin
            if (bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              sda_oe  <= 1'b0;
              ptr     <= ptr_next;
              state   <= RDATA_ACK;
            end else begin
              sda_oe <= ~tx[6];
              tx     <= {tx[5:0], 1'b0};
            end
          end
          RDATA_ACK: begin
            bit_cnt <= '0;
            if (shift[0] == ACK) begin
              tx     <= regs[ptr][6:0];
              sda_oe <= ~regs[ptr][7];
              state  <= RDATA;
            end else if (shift[0] == NAK) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
